// File: rtl/pkg_opengpu.sv
// Shared definitions for the L1-to-L2 cache line interface.
package pkg_opengpu;

  localparam int CACHE_LINE_BITS = 512;
  localparam int LINE_BEATS      = CACHE_LINE_BITS / 32;

  typedef enum logic [2:0] {
    CACHE_READ      = 3'd0,
    CACHE_WRITEBACK = 3'd1
  } cache_req_type_t;

endpackage

// File: rtl/l2_line_responder.sv
// L2-side responder: turns whole-line L1 reads/writebacks into ascending
// word beats on a narrow memory port and answers with a one-cycle response.
module l2_line_responder
  import pkg_opengpu::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_BITS       = CACHE_LINE_BITS,
  parameter int WORD_BITS       = CACHE_LINE_BITS / LINE_BEATS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [2:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_BITS-1:0]  req_wdata,
  output logic                  ready,
  output logic                  resp_valid,
  output logic [LINE_BITS-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [WORD_BITS-1:0]  mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [WORD_BITS-1:0]  mem_resp_rdata,
  output logic [31:0]           rd_lines,
  output logic [31:0]           wb_lines
);

  localparam int BEATS      = LINE_BITS / WORD_BITS;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int BYTE_OFF_W = $clog2(WORD_BITS / 8);
  localparam int OFFSET_W   = BEAT_IDX_W + BYTE_OFF_W;
  localparam int LADDR_W    = ADDR_WIDTH - OFFSET_W;
  localparam int CNT_W      = BEAT_IDX_W + 1;

  localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [LADDR_W-1:0]   line_addr_reg;
  logic                 err_reg;
  logic                 is_read_reg;
  logic [CNT_W-1:0]     issue_cnt_reg;
  logic [CNT_W-1:0]     rsp_cnt_reg;
  logic [31:0]          rd_lines_reg;
  logic [31:0]          wb_lines_reg;
  logic [WORD_BITS-1:0] line_buf_reg [BEATS];

  logic                 accept;
  logic                 beat_fire;
  logic                 rsp_take;
  logic [CNT_W-1:0]     outstanding;
  logic [LINE_BITS-1:0] line_flat;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^req_addr[OFFSET_W-1:0];

  assign ready       = (state_reg == ST_IDLE);
  assign accept      = req_valid && ready;
  assign outstanding = issue_cnt_reg - rsp_cnt_reg;

  always_comb begin
    mem_req_valid = 1'b0;
    if (state_reg == ST_READ) begin
      mem_req_valid = (issue_cnt_reg < BEATS_CNT) && (outstanding < MAX_OUT);
    end else if (state_reg == ST_WRITE) begin
      mem_req_valid = (issue_cnt_reg < BEATS_CNT);
    end
  end

  assign beat_fire = mem_req_valid && mem_req_ready;
  // Only responses to beats actually issued count; strays and extras are dropped.
  assign rsp_take  = (state_reg == ST_READ) && mem_resp_valid && (rsp_cnt_reg < issue_cnt_reg);

  assign mem_req_we    = mem_req_valid && (state_reg == ST_WRITE);
  assign mem_req_addr  = mem_req_valid
                       ? {line_addr_reg, issue_cnt_reg[BEAT_IDX_W-1:0], {BYTE_OFF_W{1'b0}}}
                       : '0;
  assign mem_req_wdata = mem_req_we ? line_buf_reg[issue_cnt_reg[BEAT_IDX_W-1:0]] : '0;

  assign resp_valid = (state_reg == ST_RESP);
  assign resp_err   = resp_valid && err_reg;
  assign resp_rdata = (resp_valid && is_read_reg) ? line_flat : '0;
  assign rd_lines   = rd_lines_reg;
  assign wb_lines   = wb_lines_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (req_type)
            CACHE_READ:      state_next = ST_READ;
            CACHE_WRITEBACK: state_next = ST_WRITE;
            default:         state_next = ST_RESP;
          endcase
        end
      end
      ST_READ:  if (rsp_take && (rsp_cnt_reg == LAST_BEAT)) state_next = ST_RESP;
      ST_WRITE: if (beat_fire && (issue_cnt_reg == LAST_BEAT)) state_next = ST_RESP;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      line_addr_reg <= '0;
      err_reg       <= 1'b0;
      is_read_reg   <= 1'b0;
      issue_cnt_reg <= '0;
      rsp_cnt_reg   <= '0;
      rd_lines_reg  <= '0;
      wb_lines_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        line_addr_reg <= req_addr[ADDR_WIDTH-1:OFFSET_W];
        err_reg       <= !((req_type == CACHE_READ) || (req_type == CACHE_WRITEBACK));
        is_read_reg   <= (req_type == CACHE_READ);
        issue_cnt_reg <= '0;
        rsp_cnt_reg   <= '0;
      end else begin
        if (beat_fire) issue_cnt_reg <= issue_cnt_reg + 1'b1;
        if (rsp_take)  rsp_cnt_reg   <= rsp_cnt_reg + 1'b1;
      end
      if ((state_reg == ST_RESP) && !err_reg) begin
        if (is_read_reg) begin
          if (rd_lines_reg != 32'hFFFF_FFFF) rd_lines_reg <= rd_lines_reg + 32'd1;
        end else begin
          if (wb_lines_reg != 32'hFFFF_FFFF) wb_lines_reg <= wb_lines_reg + 32'd1;
        end
      end
    end
  end

  // One word register per beat: loaded whole on accept, or word-by-word from read data.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (accept) begin
          line_buf_reg[gi] <= req_wdata[gi*WORD_BITS +: WORD_BITS];
        end else if (rsp_take && (rsp_cnt_reg[BEAT_IDX_W-1:0] == BEAT_IDX_W'(gi))) begin
          line_buf_reg[gi] <= mem_resp_rdata;
        end
      end
      assign line_flat[gi*WORD_BITS +: WORD_BITS] = line_buf_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: directed and random line transactions against a
// word memory model, checked against a transaction-level reference.
module tb_l2_line_responder;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [2:0]   req_type;
  logic [31:0]  req_addr;
  logic [511:0] req_wdata;
  logic         ready;
  logic         resp_valid;
  logic [511:0] resp_rdata;
  logic         resp_err;
  logic         mem_req_valid;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [31:0]  mem_resp_rdata = 32'h0;
  logic [31:0]  rd_lines;
  logic [31:0]  wb_lines;

  l2_line_responder dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_type       (req_type),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ready          (ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .rd_lines       (rd_lines),
    .wb_lines       (wb_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment knobs (written by the stimulus block only).
  int lat = 1;
  int rmode = 0;
  int junk_total = 0;
  int epoch = 0;

  // Memory environment state (written by the memory process only).
  int ecyc = 0;
  int junk_done = 0;
  int seen_epoch = 0;
  int max_out = 0;
  int n_iss = 0;
  int n_resp = 0;
  logic [31:0] pend_data[$];
  int          pend_due[$];
  logic [31:0] iss_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] mem_store [logic [31:0]];

  // Drives ready/response for the coming edge and logs the handshakes at that edge.
  always @(negedge clk) begin
    logic        r;
    logic [31:0] a;
    ecyc++;
    if (seen_epoch != epoch) begin
      seen_epoch = epoch;
      max_out = 0;
    end
    case (rmode)
      0:       r = 1'b1;
      1:       r = (ecyc % 2 == 0);
      default: r = 1'($urandom_range(0, 1));
    endcase
    mem_req_ready  = r;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    if (junk_done < junk_total) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hDEAD_BEEF;
      junk_done++;
    end else if (pend_due.size() > 0 && pend_due[0] <= ecyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = pend_data.pop_front();
      void'(pend_due.pop_front());
      n_resp++;
    end
    if (mem_req_valid && r) begin
      a = mem_req_addr;
      if (mem_req_we) begin
        mem_store[a] = mem_req_wdata;
        wr_addr_q.push_back(a);
        wr_data_q.push_back(mem_req_wdata);
      end else begin
        iss_addr_q.push_back(a);
        pend_data.push_back(mem_store.exists(a) ? mem_store[a] : (a ^ KEY));
        pend_due.push_back(ecyc + lat);
        n_iss++;
      end
    end
    if (n_iss - n_resp > max_out) max_out = n_iss - n_resp;
  end

  int checks = 0;
  int errors = 0;
  int cnt_rd_exp = 0;
  int cnt_wb_exp = 0;
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected line: written words where the line was written back, else addr^KEY.
  function automatic logic [511:0] exp_line(input logic [31:0] addr);
    logic [511:0] l;
    logic [31:0]  a;
    for (int i = 0; i < 16; i++) begin
      a = {addr[31:6], 6'b0} + 32'(4 * i);
      l[i*32 +: 32] = ref_mem.exists(a) ? ref_mem[a] : (a ^ KEY);
    end
    return l;
  endfunction

  task automatic check_beats(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [511:0] wd, input int bi, input int bw);
    logic [511:0] obs_a, exp_a, obs_d;
    int ni, nw;
    ni = iss_addr_q.size() - bi;
    nw = wr_addr_q.size() - bw;
    obs_a = '0;
    exp_a = '0;
    obs_d = '0;
    for (int i = 0; i < 16; i++) exp_a[i*32 +: 32] = {addr[31:6], 6'b0} + 32'(4 * i);
    if (typ == 3'd0) begin
      for (int i = 0; i < 16 && i < ni; i++) obs_a[i*32 +: 32] = iss_addr_q[bi + i];
      chk({tag, "_rd_beats"}, 512'(ni), 512'(16));
      chk({tag, "_wr_beats"}, 512'(nw), 512'(0));
      chk({tag, "_rd_addrs"}, obs_a, exp_a);
    end else if (typ == 3'd1) begin
      for (int i = 0; i < 16 && i < nw; i++) begin
        obs_a[i*32 +: 32] = wr_addr_q[bw + i];
        obs_d[i*32 +: 32] = wr_data_q[bw + i];
      end
      chk({tag, "_wr_beats"}, 512'(nw), 512'(16));
      chk({tag, "_rd_beats"}, 512'(ni), 512'(0));
      chk({tag, "_wr_addrs"}, obs_a, exp_a);
      chk({tag, "_wr_data"}, obs_d, wd);
    end else begin
      chk({tag, "_no_beats"}, 512'(ni + nw), 512'(0));
    end
  endtask

  // Issues one request from an idle responder and checks the whole transaction.
  task automatic run_txn(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [511:0] wd, input bit keep_busy,
                         output int n, output logic [511:0] rd);
    int   bi, bw;
    bit   got, is_rd, is_wb;
    logic e;
    is_rd = (typ == 3'd0);
    is_wb = (typ == 3'd1);
    bi = iss_addr_q.size();
    bw = wr_addr_q.size();
    epoch++;
    chk({tag, "_ready"}, 512'(ready), 512'(1));
    req_valid = 1'b1;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wd;
    step();
    n = 1;
    got = 1'b0;
    rd = '0;
    e = 1'b0;
    if (keep_busy) begin
      req_type  = 3'd1;
      req_addr  = ~addr;
      req_wdata = ~wd;
    end else begin
      req_valid = 1'b0;
    end
    while (!got && n <= 400) begin
      if (resp_valid) begin
        got = 1'b1;
        rd = resp_rdata;
        e = resp_err;
      end else begin
        step();
        n++;
      end
    end
    req_valid = 1'b0;
    chk({tag, "_resp_seen"}, 512'(got), 512'(1));
    chk({tag, "_rdata"}, rd, is_rd ? exp_line(addr) : 512'(0));
    chk({tag, "_err"}, 512'(e), 512'(!(is_rd || is_wb)));
    check_beats(tag, typ, addr, wd, bi, bw);
    if (is_wb) begin
      for (int i = 0; i < 16; i++) ref_mem[{addr[31:6], 6'b0} + 32'(4 * i)] = wd[i*32 +: 32];
      cnt_wb_exp++;
    end
    if (is_rd) cnt_rd_exp++;
    step();
    chk({tag, "_rd_lines"}, 512'(rd_lines), 512'(cnt_rd_exp));
    chk({tag, "_wb_lines"}, 512'(wb_lines), 512'(cnt_wb_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, bi, bw, bresp, sel;
    logic [511:0] rd, wd;
    logic [31:0]  a;
    logic [2:0]   t;

    rst = 1'b1;
    req_valid = 1'b0;
    req_type = 3'd0;
    req_addr = 32'h0;
    req_wdata = '0;
    step();
    step();
    chk("reset_ready", 512'(ready), 512'(1));
    chk("reset_resp_valid", 512'(resp_valid), 512'(0));
    chk("reset_mem_req_valid", 512'(mem_req_valid), 512'(0));
    chk("reset_resp_rdata", resp_rdata, 512'(0));
    chk("reset_rd_lines", 512'(rd_lines), 512'(0));
    chk("reset_wb_lines", 512'(wb_lines), 512'(0));
    rst = 1'b0;
    step();

    // Plain read, memory always ready, 1-cycle latency.
    lat = 1;
    rmode = 0;
    run_txn("s1_read", 3'd0, 32'h0000_0100, '0, 1'b0, n, rd);
    chk("s1_latency", 512'(n), 512'(18));
    chk("s1_word0", 512'(rd[31:0]), 512'(32'h5A5A_0100));
    chk("s1_word15", 512'(rd[511:480]), 512'(32'h5A5A_013C));
    chk("s1_rd_lines_one", 512'(rd_lines), 512'(1));

    // Writeback with word w = 0xC0DE_0000 | w.
    for (int w = 0; w < 16; w++) wd[w*32 +: 32] = 32'hC0DE_0000 | 32'(w);
    bw = wr_addr_q.size();
    run_txn("s2_wb", 3'd1, 32'h0000_1000, wd, 1'b0, n, rd);
    chk("s2_latency", 512'(n), 512'(17));
    chk("s2_beat3_addr", 512'(wr_addr_q[bw + 3]), 512'(32'h0000_100C));
    chk("s2_beat3_data", 512'(wr_data_q[bw + 3]), 512'(32'hC0DE_0003));
    chk("s2_wb_lines_one", 512'(wb_lines), 512'(1));

    // Stalling memory: ready toggles, 3-cycle latency.
    lat = 3;
    rmode = 1;
    run_txn("s3_read_stall", 3'd0, 32'h0000_0100, '0, 1'b0, n, rd);
    chk("s3_max_out_le4", 512'(max_out <= 4), 512'(1));

    // Unsupported type.
    lat = 1;
    rmode = 0;
    run_txn("s4_err", 3'd5, 32'h0000_0300, '1, 1'b0, n, rd);
    chk("s4_latency", 512'(n), 512'(1));

    // Unaligned read with req_valid held during the busy period.
    bi = iss_addr_q.size();
    run_txn("s5_unaligned", 3'd0, 32'h0000_0124, '0, 1'b1, n, rd);
    chk("s5_first_beat", 512'(iss_addr_q[bi]), 512'(32'h0000_0100));
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (resp_valid) cnt++;
    end
    chk("s5_no_extra_resp", 512'(cnt), 512'(0));

    // Random transactions over a small set of lines so reads hit earlier writebacks.
    for (int k = 0; k < 14; k++) begin
      sel = $urandom_range(0, 3);
      t = (sel == 1) ? 3'd1 : (sel == 2) ? 3'($urandom_range(2, 7)) : 3'd0;
      a = 32'h0000_2000 + 32'($urandom_range(0, 7) << 6) + 32'($urandom_range(0, 63));
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom;
      lat = $urandom_range(1, 4);
      rmode = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", k), t, a, wd, 1'b0, n, rd);
      chk($sformatf("rnd%0d_max_out_le4", k), 512'(max_out <= 4), 512'(1));
    end

    // Reset in the middle of a read.
    lat = 1;
    rmode = 0;
    step();
    bresp = n_resp;
    req_valid = 1'b1;
    req_type = 3'd0;
    req_addr = 32'h0000_0200;
    step();
    req_valid = 1'b0;
    n = 0;
    while ((n_resp - bresp) < 7 && n < 100) begin
      step();
      n++;
    end
    chk("s6_seven_responses", 512'((n_resp - bresp) >= 7), 512'(1));
    rst = 1'b1;
    #1;
    chk("s6_rst_ready", 512'(ready), 512'(1));
    chk("s6_rst_resp_valid", 512'(resp_valid), 512'(0));
    chk("s6_rst_mem_req_valid", 512'(mem_req_valid), 512'(0));
    chk("s6_rst_mem_req_addr", 512'(mem_req_addr), 512'(0));
    step();
    step();
    rst = 1'b0;
    junk_total = junk_total + 3;
    cnt = 0;
    n = 0;
    while ((junk_done < junk_total || pend_due.size() > 0) && n < 50) begin
      step();
      n++;
      if (resp_valid || mem_req_valid) cnt++;
    end
    step();
    chk("s6_late_drained", 512'(n < 50), 512'(1));
    chk("s6_late_ignored", 512'(cnt), 512'(0));
    chk("s6_idle_ready", 512'(ready), 512'(1));
    chk("s6_rd_lines_cleared", 512'(rd_lines), 512'(0));
    chk("s6_wb_lines_cleared", 512'(wb_lines), 512'(0));
    cnt_rd_exp = 0;
    cnt_wb_exp = 0;
    run_txn("s6_read_after", 3'd0, 32'h0000_0040, '0, 1'b0, n, rd);
    chk("s6_latency", 512'(n), 512'(18));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Responder end of the L1-to-L2 line interface: accepts whole-line read and writeback requests from an L1 data cache and answers with a single-cycle response.
- Backs onto a narrow, word-wide memory port.
- Each line is split into sequential word beats.
- Read beats are assembled into a line buffer; writeback beats are serialized out of it.
- Sits between l1_data_cache and the shared memory/SRAM model.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_BITS, 512, cache line width (CACHE_LINE_BITS); 64-byte line.
- WORD_BITS, 32, memory port data width.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered read beats.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  L1 request valid.
- req_type  in  3  request type: 3'd0 CACHE_READ, 3'd1 CACHE_WRITEBACK, others unsupported.
- req_addr  in  ADDR_WIDTH  line address; low 6 bits ignored.
- req_wdata  in  LINE_BITS  writeback line data.
- ready  out  1  responder can accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  LINE_BITS  read line data, valid with resp_valid.
- resp_err  out  1  unsupported req_type, valid with resp_valid.
- mem_req_valid  out  1  memory beat request.
- mem_req_we  out  1  beat is a write.
- mem_req_addr  out  ADDR_WIDTH  beat byte address.
- mem_req_wdata  out  WORD_BITS  write beat data.
- mem_req_ready  in  1  memory accepts beat this cycle.
- mem_resp_valid  in  1  read beat data valid; responses return in issue order.
- mem_resp_rdata  in  WORD_BITS  read beat data.
- rd_lines  out  32  count of completed line reads, saturating.
- wb_lines  out  32  count of completed writebacks, saturating.

Behaviour:
- Reset values: ready=1, all other outputs 0, state IDLE, all counters 0.
- Accept condition: req_valid && ready.
  - On accept, latch type, addr[31:6] and req_wdata; later changes to request inputs have no effect.
  - req_valid while ready=0 is ignored; there is no queueing.
- ready=1 only in IDLE and drops the cycle after accept.
- Beat i (0..15, ascending):
  - address = {addr[31:6], i[3:0], 2'b00};
  - data = line[i*WORD_BITS +: WORD_BITS].
- States:
  - IDLE: on accept of type 0 go to READ, type 1 go to WRITE, other types go to RESP with err=1.
  - READ:
    - Issue beat when issue_cnt<16 and outstanding<MAX_OUTSTANDING, with mem_req_valid=1, we=0.
    - A beat advances only when mem_req_ready=1; mem_req_valid stays high and the address stays stable while stalled.
    - Each mem_resp_valid writes the next word (rsp_cnt) into the buffer.
    - Simultaneous issue and response in one cycle leaves outstanding unchanged.
    - After the 16th response, go to RESP.
  - WRITE:
    - Issue 16 write beats (we=1), same stall rules as READ.
    - After the 16th accepted beat, go to RESP.
    - No memory response is expected; any mem_resp_valid here is ignored.
  - RESP:
    - resp_valid=1 for exactly one cycle.
    - resp_rdata = buffer for reads; resp_rdata = 0 for writeback and error.
    - Increment rd_lines or wb_lines on success (saturate at 2^32-1).
    - Go to IDLE.
- Latency with memory always ready and 1-cycle read latency (accept edge = cycle 0):
  - read: beats issued cycles 1..16, responses cycles 2..17, resp_valid cycle 18;
  - writeback: beats cycles 1..16, resp_valid cycle 17;
  - error: resp_valid cycle 1.
- mem_resp_valid in IDLE/WRITE/RESP is dropped, as is any response beyond the 16th.
- Reset mid-operation:
  - immediately returns all outputs to reset values and the state to IDLE, discarding the partial line;
  - after release, late memory responses are dropped.
- issue_cnt and rsp_cnt are 5-bit; they never wrap past 16.

Decomposition:
- pkg_opengpu:
  - CACHE_LINE_BITS;
  - cache_req_type_t enum (CACHE_READ=3'd0, CACHE_WRITEBACK=3'd1);
  - LINE_BEATS = CACHE_LINE_BITS/32.
- The state enum stays local to the module.
- No sub-module; the line buffer and counters are inline.

Test Plan:
- Read 0x0000_0100; memory word at byte address A returns A^32'h5A5A_0000 with 1-cycle latency and ready held 1 -> 16 reads at addresses 0x100..0x13C. Required response: resp_valid on cycle 18, resp_rdata[31:0]=0x5A5A_0100, resp_rdata[511:480]=0x5A5A_013C, rd_lines=1.
- Writeback 0x0000_1000 with word w = 0xC0DE_0000|w -> 16 writes in ascending order. Required response: beat 3 at address 0x100C with data 0xC0DE_0003, resp_valid on cycle 17, resp_err=0, wb_lines=1.
- Read with mem_req_ready alternating 1/0 and 3-cycle response latency -> exactly 16 issued beats, none duplicated, outstanding never exceeds 4, line data identical to scenario 1.
- req_type=3'd5 -> no mem_req_valid. Required response: resp_valid with resp_err=1 on cycle 1, resp_rdata=0, counters unchanged.
- Unaligned read 0x0000_0124 -> first beat address 0x100; req_valid asserted during busy is ignored (no second response).
- Assert rst after 7 read responses -> ready=1 and resp_valid=0 immediately. Late mem_resp_valid pulses are ignored, and a following read of 0x0000_0040 returns the correct line.
